// File: rtl/unit2_wb_merge.sv
// Writeback merger: buffers ALU/MEM/IO result streams in per-source FIFOs and
// drains them onto the single register-file write port with MEM > ALU > IO priority.
module unit2_wb_merge #(
  parameter int DEPTH    = 4,
  parameter int STALL_TH = 2,
  parameter int AW       = 6,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_dd_val,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dd_val,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_dd_val,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_val,
  output logic          stall,
  output logic          overflow
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          NSRC      = 3;
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [PW:0] STALL_CNT = (PW+1)'(DEPTH - STALL_TH);

  // Source index order doubles as arbitration priority: 0 = MEM, 1 = ALU, 2 = IO.
  logic [AW-1:0]   src_addr  [NSRC];
  logic [DW-1:0]   src_val   [NSRC];
  logic [AW-1:0]   fifo_addr [NSRC][DEPTH];
  logic [DW-1:0]   fifo_val  [NSRC][DEPTH];
  logic [PW-1:0]   wptr      [NSRC];
  logic [PW-1:0]   rptr      [NSRC];
  logic [PW:0]     cnt       [NSRC];
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] accept;
  logic [NSRC-1:0] drop;

  logic            win_vld_p0;
  logic [AW-1:0]   win_addr_p0;
  logic [DW-1:0]   win_val_p0;
  logic            wb_en_p1;
  logic [AW-1:0]   wb_addr_p1;
  logic [DW-1:0]   wb_val_p1;

  assign src_addr[0] = mem_addr;
  assign src_val[0]  = mem_dd_val;
  assign src_addr[1] = alu_addr;
  assign src_val[1]  = alu_dd_val;
  assign src_addr[2] = io_addr;
  assign src_val[2]  = io_dd_val;

  // ---- stage p0: arbitration over FIFO heads (state before this edge's pushes)
  always_comb begin
    push        = '0;
    pop         = '0;
    accept      = '0;
    drop        = '0;
    win_vld_p0  = 1'b0;
    win_addr_p0 = '0;
    win_val_p0  = '0;
    for (int s = 0; s < NSRC; s++) begin
      push[s] = (src_addr[s] != '0);
      if (!win_vld_p0 && (cnt[s] != '0)) begin
        win_vld_p0  = 1'b1;
        pop[s]      = 1'b1;
        win_addr_p0 = fifo_addr[s][rptr[s]];
        win_val_p0  = fifo_val[s][rptr[s]];
      end
    end
    // A full FIFO still accepts when its head leaves on the same edge.
    for (int s = 0; s < NSRC; s++) begin
      accept[s] = push[s] && ((cnt[s] != FULL_CNT) || pop[s]);
      drop[s]   = push[s] && !accept[s];
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      stall = stall | (cnt[s] >= STALL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < NSRC; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
      overflow   <= 1'b0;
      wb_en_p1   <= 1'b0;
      wb_addr_p1 <= '0;
      wb_val_p1  <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (accept[s]) wptr[s] <= wptr[s] + 1'b1;
        if (pop[s])    rptr[s] <= rptr[s] + 1'b1;
        case ({accept[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + 1'b1;
          2'b01:   cnt[s] <= cnt[s] - 1'b1;
          default: cnt[s] <= cnt[s];
        endcase
      end
      if (|drop) overflow <= 1'b1;
      // ---- stage p1: registered write port
      wb_en_p1   <= win_vld_p0;
      wb_addr_p1 <= win_addr_p0;
      wb_val_p1  <= win_val_p0;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (accept[s]) begin
        fifo_addr[s][wptr[s]] <= src_addr[s];
        fifo_val[s][wptr[s]]  <= src_val[s];
      end
    end
  end

  assign wb_en   = wb_en_p1;
  assign wb_addr = wb_addr_p1;
  assign wb_val  = wb_val_p1;

endmodule
